// File: rtl/dice_if.sv
// rtl/dice_if.sv - button/tick inputs and counter/display control outputs of the dice sequencer
// Signals:
//   tick     32 Hz one-cycle pulse from the prescaler
//   btn      debounced die buttons, bit 0..6 = d4, d6, d8, d10, d12, d20, d100
//   die_sel  captured die index
//   load     counter load-maximum strobe
//   step     counter decrement strobe
//   blank    display blank request
//   busy     sequencer not idle
//   done     roll-complete strobe
// Modports: master drives tick/btn (button side), slave is the sequencer.
interface dice_if;
    logic       tick;
    logic [6:0] btn;
    logic [2:0] die_sel;
    logic       load;
    logic       step;
    logic       blank;
    logic       busy;
    logic       done;

    modport master (
        output tick, btn,
        input  die_sel, load, step, blank, busy, done
    );

    modport slave (
        input  tick, btn,
        output die_sel, load, step, blank, busy, done
    );
endinterface

// File: rtl/dice_roll_sequencer.sv
// rtl/dice_roll_sequencer.sv - die-button arbiter and roll/coast sequencer for the two-digit dice counter
// Optional feature macro: DICE_COAST_EN (after release, coast to a stop with a slowing step rate).
// Parameter (only with DICE_COAST_EN): COAST_STEPS, number of coast steps after release, 1..8.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dice_if.slave: tick, btn in; die_sel, load, step, blank, busy, done out (all registered)
module dice_roll_sequencer
`ifdef DICE_COAST_EN
#(
    parameter int COAST_STEPS = 5
)
`endif
(
    input  logic  clk,
    input  logic  rst_n,
    dice_if.slave bus
);

`ifdef DICE_COAST_EN
    typedef enum logic [1:0] {IDLE, ROLL, COAST} state_t;
    localparam logic [2:0] LAST_K = 3'(COAST_STEPS - 1);
`else
    typedef enum logic [1:0] {IDLE, ROLL} state_t;
`endif

    state_t     state, state_nxt;
    logic       anybtn, anybtn_q, armed, press;
    logic [2:0] sel_lo;
    logic [2:0] die_sel_q, die_sel_nxt;
    logic       load_q, load_nxt;
    logic       step_q, step_nxt;
    logic       done_q, done_nxt;
    logic       blank_q, busy_q;

`ifdef DICE_COAST_EN
    logic [7:0] tcnt, tcnt_nxt;
    logic [2:0] k, k_nxt;
    logic       coast_hit;

    // Coast step k is due once 2^k ticks have elapsed since the previous one.
    assign coast_hit = ({1'b0, tcnt} + 9'd1) == (9'd1 << k);
`else
    logic unused_tick;
    assign unused_tick = bus.tick;
`endif

    assign anybtn = |bus.btn;
    // armed stays low while a button is held out of reset, so that hold is
    // never mistaken for a fresh press.
    assign press  = anybtn && !anybtn_q && armed;

    // Lowest-numbered held button wins.
    always_comb begin
        sel_lo = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bus.btn[i]) sel_lo = 3'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        die_sel_nxt = die_sel_q;
        load_nxt    = 1'b0;
        step_nxt    = 1'b0;
        done_nxt    = 1'b0;
`ifdef DICE_COAST_EN
        tcnt_nxt    = tcnt;
        k_nxt       = k;
`endif
        case (state)
            IDLE: begin
                if (press) begin
                    die_sel_nxt = sel_lo;
                    load_nxt    = 1'b1;
                    state_nxt   = ROLL;
                end
            end
            ROLL: begin
                if (anybtn) begin
                    step_nxt = 1'b1;
                end else begin
`ifdef DICE_COAST_EN
                    state_nxt = COAST;
                    tcnt_nxt  = 8'd0;
                    k_nxt     = 3'd0;
`else
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef DICE_COAST_EN
            COAST: begin
                // A re-press takes priority over a coincident tick.
                if (press) begin
                    die_sel_nxt = sel_lo;
                    load_nxt    = 1'b1;
                    state_nxt   = ROLL;
                end else if (bus.tick) begin
                    if (coast_hit) begin
                        step_nxt = 1'b1;
                        tcnt_nxt = 8'd0;
                        k_nxt    = k + 3'd1;
                        if (k == LAST_K) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        tcnt_nxt = tcnt + 8'd1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            anybtn_q  <= 1'b0;
            armed     <= 1'b0;
            die_sel_q <= 3'd0;
            load_q    <= 1'b0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            blank_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DICE_COAST_EN
            tcnt      <= 8'd0;
            k         <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            anybtn_q  <= anybtn;
            if (!anybtn) armed <= 1'b1;
            die_sel_q <= die_sel_nxt;
            load_q    <= load_nxt;
            step_q    <= step_nxt;
            done_q    <= done_nxt;
            blank_q   <= (state_nxt == ROLL);
            busy_q    <= (state_nxt != IDLE);
`ifdef DICE_COAST_EN
            tcnt      <= tcnt_nxt;
            k         <= k_nxt;
`endif
        end
    end

    assign bus.die_sel = die_sel_q;
    assign bus.load    = load_q;
    assign bus.step    = step_q;
    assign bus.done    = done_q;
    assign bus.blank   = blank_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb/tb_dice_roll_sequencer.sv - scoreboard bench for dice_roll_sequencer (default and DICE_COAST_EN builds)
module tb_dice_roll_sequencer;
`ifdef DICE_COAST_EN
    localparam int CS   = 5;
    localparam int FULL = (1 << CS) - 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int kind;   // 0 load, 1 step, 2 done
        int at;     // cycle count at which the strobe is visible
        int die;
    } ev_t;

    ev_t exp_q[$];
    ev_t drop;

    dice_if bus();

`ifdef DICE_COAST_EN
    dice_roll_sequencer #(.COAST_STEPS(CS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
`else
    dice_roll_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "load";
            1: return "step";
            default: return "done";
        endcase
    endfunction

    function automatic int lowest(input logic [6:0] p);
        for (int i = 0; i < 7; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int die);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.die  = die;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation for every strobe the DUT presents.
    task automatic take(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s at cyc %0d die_sel=%0d, nothing expected", kname(kind), cyc, bus.die_sel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || e.die != int'(bus.die_sel)) begin
                errors++;
                $display("FAIL event actual=%s@%0d die %0d required=%s@%0d die %0d",
                         kname(kind), cyc, bus.die_sel, kname(e.kind), e.at, e.die);
            end
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_%s required at cyc %0d, actual none by cyc %0d", kname(exp_q[0].kind), exp_q[0].at, cyc);
            drop = exp_q.pop_front();
        end
        if (bus.load) begin
            take(0);
            checks++;
            if (bus.step) begin
                errors++;
                $display("FAIL load_step_overlap actual step=1 required step=0 (cyc %0d)", cyc);
            end
        end
        if (bus.step) take(1);
        if (bus.done) take(2);
    end

    task automatic nxt(input logic tk);
        @(negedge clk);
        bus.tick = tk;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt($urandom_range(0, 1) == 1);
    endtask

    // Press pat (optionally with a tick in the same cycle), hold for `hold`
    // cycles counting the press cycle, optionally switch to alt mid-roll, release.
    task automatic roll(input logic [6:0] pat, input logic press_tick, input int hold, input logic [6:0] alt);
        int c;
        int d;
        d = lowest(pat);
        nxt(press_tick);
        bus.btn = pat;
        c = cyc;
        push(0, c + 1, d);
        for (int j = 2; j <= hold; j++) push(1, c + j, d);
        nxt(1'b0);
        chk("press_blank", int'(bus.blank), 1);
        chk("press_busy", int'(bus.busy), 1);
        for (int j = 2; j <= hold; j++) begin
            nxt($urandom_range(0, 1) == 1);
            if (j == hold) begin
                bus.btn  = '0;
                bus.tick = 1'b0;
            end else if (alt != 0 && j == 2) begin
                bus.btn = alt;
            end
        end
`ifndef DICE_COAST_EN
        push(2, c + hold + 1, d);
`endif
        nxt(1'b0);
        chk("release_step", int'(bus.step), 0);
        chk("release_blank", int'(bus.blank), 0);
        chk("die_held", int'(bus.die_sel), d);
`ifdef DICE_COAST_EN
        chk("coast_busy", int'(bus.busy), 1);
`else
        chk("done_busy", int'(bus.busy), 0);
`endif
    endtask

`ifdef DICE_COAST_EN
    // Deliver coast ticks 1..stop_at with random spacing; step j is due on
    // cumulative tick 2^(j+1)-1, the last one also completes the roll.
    task automatic coast_run(input int stop_at, input int d);
        for (int n = 1; n <= stop_at; n++) begin
            repeat ($urandom_range(0, 2)) nxt(1'b0);
            nxt(1'b1);
            for (int j = 0; j < CS; j++) begin
                if (n == (1 << (j + 1)) - 1) begin
                    push(1, cyc + 1, d);
                    if (j == CS - 1) push(2, cyc + 1, d);
                end
            end
        end
        if (stop_at == FULL) begin
            nxt(1'b0);
            chk("coast_end_busy", int'(bus.busy), 0);
            chk("coast_end_blank", int'(bus.blank), 0);
        end
    endtask
`endif

    task automatic after_release(input int d);
`ifdef DICE_COAST_EN
        coast_run(FULL, d);
        idle(3);
`else
        if (d < 0) $display("bad die");
        idle(6);
`endif
    endtask

    initial begin
        logic [6:0] p;
        logic [6:0] alt;
        int         hold;
        int         c;

        bus.tick = 1'b0;
        bus.btn  = '0;
        #1;
        chk("reset_outputs", int'({bus.die_sel, bus.load, bus.step, bus.blank, bus.busy, bus.done}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("idle_busy", int'(bus.busy), 0);

        roll(7'b0000001, 1'b0, 6, 7'd0);
        after_release(0);

        roll(7'b1010100, 1'b0, 8, 7'b0000001);
        after_release(2);

`ifdef DICE_COAST_EN
        // Abort on the tick that would have produced coast step 3.
        roll(7'b0001000, 1'b0, 4, 7'd0);
        coast_run(6, 3);
        roll(7'b1000000, 1'b1, 5, 7'd0);
        after_release(6);
`endif

        for (int i = 0; i < 6; i++) begin
            p    = 7'($urandom_range(1, 127));
            hold = $urandom_range(2, 12);
            alt  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            idle($urandom_range(1, 4));
            roll(p, 1'b0, hold, alt);
            after_release(lowest(p));
        end

        // Asynchronous reset in the middle of a roll, button held throughout.
        nxt(1'b0);
        bus.btn = 7'b0000100;
        c = cyc;
        push(0, c + 1, 2);
        for (int j = 2; j <= 4; j++) push(1, c + j, 2);
        repeat (4) nxt(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midroll_reset_outputs", int'({bus.die_sel, bus.load, bus.step, bus.blank, bus.busy, bus.done}), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(6);
        chk("held_after_reset_busy", int'(bus.busy), 0);
        nxt(1'b0);
        bus.btn = '0;
        idle(3);
        roll(7'b0100000, 1'b0, 5, 7'd0);
        after_release(5);

        idle(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (30000) @(posedge clk);
        errors++;
        $display("FAIL timeout actual=%0d cycles required=finish earlier", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
